// File: rtl/aes_pkg.sv
// Shared AES definitions: legal key sizes, round count per key size,
// the round-engine state encoding and the 128-bit block type.
package aes_pkg;

  localparam int unsigned KEY_SIZE_128 = 128;
  localparam int unsigned KEY_SIZE_192 = 192;
  localparam int unsigned KEY_SIZE_256 = 256;
  localparam int unsigned STATE_W      = 128;

  typedef logic [STATE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } engine_state_e;

  function automatic bit key_size_legal(input int unsigned key_size);
    return (key_size == KEY_SIZE_128) || (key_size == KEY_SIZE_192) ||
           (key_size == KEY_SIZE_256);
  endfunction

  // Illegal sizes map to 0 so the engine's elaboration check is the single point of failure.
  function automatic int unsigned num_rounds(input int unsigned key_size);
    case (key_size)
      KEY_SIZE_128: return 10;
      KEY_SIZE_192: return 12;
      KEY_SIZE_256: return 14;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES round, forward or inverse, with the MixColumns-free
// final-round variants. Byte 0 of the block sits in bits [127:120].
module aes_round_unit
  import aes_pkg::*;
(
  input  aes_state_t state_i,
  input  aes_state_t round_key_i,
  input  logic       decrypt_i,
  input  logic       final_i,
  output aes_state_t next_state_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic aes_state_t sub_bytes(input aes_state_t s, input logic inv);
    aes_state_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv ? sbox_inv(s[8*i +: 8]) : sbox_fwd(s[8*i +: 8]);
    end
    return r;
  endfunction

  function automatic aes_state_t shift_rows(input aes_state_t s, input logic inv);
    aes_state_t r;
    int src;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        src = inv ? (c + 4 - row) % 4 : (c + row) % 4;
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*src) -: 8];
      end
    end
    return r;
  endfunction

  function automatic aes_state_t mix_columns(input aes_state_t s, input logic inv);
    aes_state_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      if (inv) begin
        r[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        r[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        r[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        r[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end else begin
        r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return r;
  endfunction

  aes_state_t enc_shifted;
  aes_state_t enc_result;
  aes_state_t dec_keyed;
  aes_state_t dec_result;

  always_comb begin
    enc_shifted  = shift_rows(sub_bytes(state_i, 1'b0), 1'b0);
    enc_result   = (final_i ? enc_shifted : mix_columns(enc_shifted, 1'b0)) ^ round_key_i;
    dec_keyed    = sub_bytes(shift_rows(state_i, 1'b1), 1'b1) ^ round_key_i;
    dec_result   = final_i ? dec_keyed : mix_columns(dec_keyed, 1'b1);
    next_state_o = decrypt_i ? dec_result : enc_result;
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES cipher / inverse cipher: one full round per clock over a single
// 128-bit state register, round keys fetched per cycle through rk_index/rk_data.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int unsigned KEY_SIZE = 128
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_decrypt,
  output logic [3:0]   rk_index,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_decrypt
);

  localparam int unsigned NUM_ROUNDS = num_rounds(KEY_SIZE);
  localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);

  if (!key_size_legal(KEY_SIZE)) begin : g_bad_key_size
    $error("aes_round_engine: KEY_SIZE must be 128, 192 or 256");
  end

  engine_state_e fsm_q;
  logic [3:0]    round_ctr_q;
  logic          mode_q;
  aes_state_t    data_q;
  aes_state_t    data_d;
  aes_state_t    round_out;
  logic          accept;
  logic          last_round;

  assign in_ready   = reset_n && ((fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign last_round = (round_ctr_q == LAST_ROUND);

  // Outside ROUND the index follows in_decrypt so the whitening key is already settled for an accept.
  assign rk_index = (fsm_q == ST_ROUND) ? (mode_q ? LAST_ROUND - round_ctr_q : round_ctr_q)
                                        : (in_decrypt ? LAST_ROUND : 4'd0);

  aes_round_unit u_round (
    .state_i     (data_q),
    .round_key_i (rk_data),
    .decrypt_i   (mode_q),
    .final_i     (last_round),
    .next_state_o(round_out)
  );

  always_comb begin
    data_d = data_q;
    if (accept) begin
      data_d = in_data ^ rk_data;
    end else if (fsm_q == ST_ROUND) begin
      data_d = round_out;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= ST_IDLE;
      round_ctr_q <= '0;
      mode_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      data_q <= data_d;
      if (accept) begin
        fsm_q       <= ST_ROUND;
        round_ctr_q <= 4'd1;
        mode_q      <= in_decrypt;
      end else begin
        case (fsm_q)
          ST_ROUND: begin
            if (last_round) fsm_q <= ST_DONE;
            else            round_ctr_q <= round_ctr_q + 4'd1;
          end
          ST_DONE: begin
            if (out_ready) begin
              fsm_q       <= ST_IDLE;
              round_ctr_q <= '0;
            end
          end
          default: fsm_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_valid   = (fsm_q == ST_DONE);
  assign out_data    = data_q;
  assign out_decrypt = mode_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Scoreboard bench for aes_round_engine: FIPS-197 vectors on 128/192/256-bit
// instances, round-key lookup served by an independent key-expansion model.
module tb_aes_round_engine;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    int           dut;
    logic [127:0] data;
    logic         decrypt;
  } expect_t;

  logic         clock = 1'b0;
  logic         resetN;
  logic         inValid    [3];
  logic         inReady    [3];
  logic         inDecrypt  [3];
  logic         outValid   [3];
  logic         outReady   [3];
  logic         outDecrypt [3];
  logic [127:0] inData     [3];
  logic [127:0] rkData     [3];
  logic [127:0] outData    [3];
  logic [3:0]   rkIndex    [3];

  logic [127:0] keySched [3][16];
  logic [7:0]   sboxTab  [256];
  expect_t      scoreboard[$];
  int           acceptCount [3];
  int           cycleCount = 0;
  int           vectors    = 0;
  int           miscompares = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cycleCount <= cycleCount + 1;

  assign rkData[0] = keySched[0][rkIndex[0]];
  assign rkData[1] = keySched[1][rkIndex[1]];
  assign rkData[2] = keySched[2][rkIndex[2]];

  aes_round_engine #(.KEY_SIZE(128)) dut128 (
    .clock(clock), .reset_n(resetN),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]), .in_decrypt(inDecrypt[0]),
    .rk_index(rkIndex[0]), .rk_data(rkData[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]), .out_decrypt(outDecrypt[0])
  );

  aes_round_engine #(.KEY_SIZE(192)) dut192 (
    .clock(clock), .reset_n(resetN),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]), .in_decrypt(inDecrypt[1]),
    .rk_index(rkIndex[1]), .rk_data(rkData[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]), .out_decrypt(outDecrypt[1])
  );

  aes_round_engine #(.KEY_SIZE(256)) dut256 (
    .clock(clock), .reset_n(resetN),
    .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]), .in_decrypt(inDecrypt[2]),
    .rk_index(rkIndex[2]), .rk_data(rkData[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_data(outData[2]), .out_decrypt(outDecrypt[2])
  );

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box built by walking the multiplicative group with generator 3.
  task automatic buildSbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sboxTab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxTab[0] = 8'h63;
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
  endfunction

  // Key bytes are 00,01,02,... as in the FIPS-197 appendix vectors.
  task automatic expandKey(input int k, input int nk);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
      end else begin
        temp = w[i-1];
        if (i % nk == 0) begin
          temp = subWord({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
          rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          temp = subWord(temp);
        end
        w[i] = w[i-nk] ^ temp;
      end
    end
    for (int r = 0; r <= nr; r++) keySched[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic checkValue(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [127:0] data, input logic dec, input logic [127:0] expData);
    int waited;
    inValid[k]   = 1'b1;
    inData[k]    = data;
    inDecrypt[k] = dec;
    #1;
    waited = 0;
    while (inReady[k] !== 1'b1 && waited < 100) begin
      @(negedge clock);
      #1;
      waited++;
    end
    checkValue($sformatf("dut%0d accept", k), 128'(inReady[k]), 128'd1);
    acceptCount[k] = cycleCount;
    scoreboard.push_back('{dut: k, data: expData, decrypt: dec});
    @(negedge clock);
    inValid[k] = 1'b0;
  endtask

  // Offer a new block in the same cycle the pending result is taken.
  task automatic chainAccept(input int k, input logic [127:0] data, input logic dec, input logic [127:0] expData);
    inValid[k]   = 1'b1;
    inData[k]    = data;
    inDecrypt[k] = dec;
    outReady[k]  = 1'b1;
    #1;
    checkValue($sformatf("dut%0d chain in_ready", k), 128'(inReady[k]), 128'd1);
    checkValue($sformatf("dut%0d chain out_valid", k), 128'(outValid[k]), 128'd1);
    acceptCount[k] = cycleCount;
    scoreboard.push_back('{dut: k, data: expData, decrypt: dec});
    @(negedge clock);
    inValid[k]  = 1'b0;
    outReady[k] = 1'b0;
    checkValue($sformatf("dut%0d chain handover", k), 128'(outValid[k]), 128'd0);
  endtask

  task automatic checkOutput(input int k, input int expLatency, input int holdCycles, input bit handshake);
    int      waited;
    int      readyBusy;
    expect_t e;
    waited    = 0;
    readyBusy = 0;
    while (outValid[k] !== 1'b1 && waited < 100) begin
      if (inReady[k] === 1'b1) readyBusy++;
      @(negedge clock);
      waited++;
    end
    checkValue($sformatf("dut%0d latency", k), 128'(cycleCount - acceptCount[k]), 128'(expLatency));
    checkValue($sformatf("dut%0d in_ready while busy", k), 128'(readyBusy), 128'd0);
    checkValue($sformatf("dut%0d scoreboard occupied", k), 128'(scoreboard.size() != 0), 128'd1);
    e = '{dut: k, data: 'x, decrypt: 1'bx};
    if (scoreboard.size() != 0) e = scoreboard.pop_front();
    checkValue($sformatf("dut%0d out_data", k), outData[e.dut], e.data);
    checkValue($sformatf("dut%0d out_decrypt", k), 128'(outDecrypt[e.dut]), 128'(e.decrypt));
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clock);
      checkValue($sformatf("dut%0d hold data %0d", k, i), outData[k], e.data);
      checkValue($sformatf("dut%0d hold valid %0d", k, i), 128'(outValid[k]), 128'd1);
      checkValue($sformatf("dut%0d hold in_ready %0d", k, i), 128'(inReady[k]), 128'd0);
    end
    if (handshake) begin
      outReady[k] = 1'b1;
      @(negedge clock);
      outReady[k] = 1'b0;
      checkValue($sformatf("dut%0d released", k), 128'(outValid[k]), 128'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int highs;
    resetN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inValid[k]   = 1'b0;
      inDecrypt[k] = 1'b0;
      inData[k]    = '0;
      outReady[k]  = 1'b0;
      acceptCount[k] = 0;
      for (int r = 0; r < 16; r++) keySched[k][r] = '0;
    end
    buildSbox();
    expandKey(0, 4);
    expandKey(1, 6);
    expandKey(2, 8);

    // Reset state, including index generation while idle in decrypt mode.
    inDecrypt[0] = 1'b1;
    repeat (3) @(negedge clock);
    checkValue("reset out_valid", 128'(outValid[0]), 128'd0);
    checkValue("reset in_ready", 128'(inReady[0]), 128'd0);
    checkValue("reset out_data", outData[0], 128'd0);
    checkValue("reset out_decrypt", 128'(outDecrypt[0]), 128'd0);
    checkValue("reset rk_index dec", 128'(rkIndex[0]), 128'd10);
    checkValue("reset rk_index enc", 128'(rkIndex[2]), 128'd0);
    resetN = 1'b1;
    @(negedge clock);
    checkValue("release in_ready", 128'(inReady[0]), 128'd1);
    inDecrypt[0] = 1'b0;

    $display("[TB] AES-128 encrypt");
    applyStimulus(0, PT, 1'b0, CT128);
    checkOutput(0, 11, 0, 1'b1);

    $display("[TB] AES-128 decrypt with round-key index trace");
    inValid[0]   = 1'b1;
    inData[0]    = CT128;
    inDecrypt[0] = 1'b1;
    #1;
    checkValue("dec in_ready", 128'(inReady[0]), 128'd1);
    checkValue("dec rk_index accept", 128'(rkIndex[0]), 128'd10);
    acceptCount[0] = cycleCount;
    scoreboard.push_back('{dut: 0, data: PT, decrypt: 1'b1});
    for (int r = 1; r <= 10; r++) begin
      @(negedge clock);
      inValid[0] = 1'b0;
      checkValue($sformatf("dec rk_index round %0d", r), 128'(rkIndex[0]), 128'(10 - r));
    end
    checkOutput(0, 11, 0, 1'b1);

    $display("[TB] AES-192 and AES-256");
    applyStimulus(1, PT, 1'b0, CT192);
    checkOutput(1, 13, 0, 1'b1);
    applyStimulus(2, PT, 1'b0, CT256);
    checkOutput(2, 15, 0, 1'b1);
    applyStimulus(2, CT256, 1'b1, PT);
    checkOutput(2, 15, 0, 1'b1);

    $display("[TB] backpressure then zero-bubble handover");
    applyStimulus(0, PT, 1'b0, CT128);
    checkOutput(0, 11, 20, 1'b0);
    chainAccept(0, CT128, 1'b1, PT);
    checkOutput(0, 11, 0, 1'b1);

    $display("[TB] in_valid held while busy");
    applyStimulus(0, PT, 1'b0, CT128);
    inValid[0]   = 1'b1;
    inData[0]    = CT128;
    inDecrypt[0] = 1'b1;
    checkOutput(0, 11, 0, 1'b0);
    chainAccept(0, CT128, 1'b1, PT);
    checkOutput(0, 11, 0, 1'b1);

    $display("[TB] reset during round 5");
    applyStimulus(0, PT, 1'b0, CT128);
    repeat (4) @(negedge clock);
    resetN = 1'b0;
    #1;
    void'(scoreboard.pop_back());
    checkValue("midreset out_valid", 128'(outValid[0]), 128'd0);
    checkValue("midreset in_ready", 128'(inReady[0]), 128'd0);
    checkValue("midreset out_data", outData[0], 128'd0);
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    checkValue("midreset in_ready after release", 128'(inReady[0]), 128'd1);
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      if (outValid[0] !== 1'b0) highs++;
      @(negedge clock);
    end
    checkValue("midreset no output", 128'(highs), 128'd0);
    applyStimulus(0, PT, 1'b0, CT128);
    checkOutput(0, 11, 0, 1'b1);

    checkValue("scoreboard drained", 128'(scoreboard.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
